// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// multi-cycle mult/div occupancy and stall/flush performance counters.
module hazard_ctrl #(
    parameter int MD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_RegAddrI,
    input  logic [4:0]  IFID_rs,
    input  logic [4:0]  IFID_rt,
    input  logic        IFID_UsesRt,
    input  logic        branch_taken,
    input  logic        md_start,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        md_done,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] MDBUSY = 2'd1;
    localparam logic [1:0] MDDONE = 2'd2;

    // The start cycle and the MDDONE cycle both let the PC advance,
    // so MDBUSY runs MD_CYCLES-1 cycles: counts MD_LOAD down to 0.
    localparam logic [4:0] MD_LOAD = 5'(MD_CYCLES - 2);

    logic [4:0] mdCnt;
    logic [1:0] nextState;
    logic       loadUse;

    assign loadUse = IDEX_MemRead && (IDEX_RegAddrI != 5'd0) &&
                     ((IDEX_RegAddrI == IFID_rs) ||
                      (IFID_UsesRt && (IDEX_RegAddrI == IFID_rt)));

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFID_flush = 1'b0;
        IDEX_flush = 1'b0;
        md_done    = 1'b0;
        nextState  = state;
        if (!rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            nextState  = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        IFID_flush = 1'b1;
                        IDEX_flush = 1'b1;
                    end else if (md_start) begin
                        nextState = MDBUSY;
                    end else if (loadUse) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_flush = 1'b1;
                    end
                end
                MDBUSY: begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEX_flush = 1'b1;
                    if (mdCnt == 5'd0)
                        nextState = MDDONE;
                end
                MDDONE: begin
                    md_done   = 1'b1;
                    nextState = RUN;
                    if (loadUse) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEX_flush = 1'b1;
                    end
                end
                default: nextState = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            mdCnt     <= 5'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= nextState;
            if (state == RUN && nextState == MDBUSY)
                mdCnt <= MD_LOAD;
            else if (state == MDBUSY && mdCnt != 5'd0)
                mdCnt <= mdCnt - 5'd1;
            if (!PCWrite && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (IFID_flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MD_CYCLES=8.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_RegAddrI;
    logic [4:0]  IFID_rs;
    logic [4:0]  IFID_rt;
    logic        IFID_UsesRt;
    logic        branch_taken;
    logic        md_start;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        md_done;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int vectors = 0;
    int errors  = 0;

    hazard_ctrl #(.MD_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegAddrI(IDEX_RegAddrI),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_UsesRt(IFID_UsesRt),
        .branch_taken(branch_taken), .md_start(md_start),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
        .md_done(md_done), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic clearInputs();
        IDEX_MemRead  = 1'b0;
        IDEX_RegAddrI = 5'd0;
        IFID_rs       = 5'd0;
        IFID_rt       = 5'd0;
        IFID_UsesRt   = 1'b0;
        branch_taken  = 1'b0;
        md_start      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearInputs();
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        tick();
        tick();
        vectors++;
        if ({PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done} !== 5'b00110) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00110",
                     {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done});
        end
        vectors++;
        if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state got st=%0d sc=%0d fc=%0d want 0/0/0",
                     state, stall_cnt, flush_cnt);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done} !== 5'b11000) begin
            errors++;
            $display("FAIL run_defaults got %b want 11000",
                     {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done});
        end
    endtask

    task automatic test_load_use();
        doReset();
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd5;
        IFID_rs       = 5'd5;
        #1;
        vectors++;
        if ({PCWrite, IFIDWrite, IFID_flush, IDEX_flush} !== 4'b0001) begin
            errors++;
            $display("FAIL loaduse_rs got %b want 0001",
                     {PCWrite, IFIDWrite, IFID_flush, IDEX_flush});
        end
        tick();
        clearInputs();
        #1;
        vectors++;
        if (stall_cnt !== 16'd1 || state !== 2'd0 || PCWrite !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_after got sc=%0d st=%0d pcw=%b want 1/0/1",
                     stall_cnt, state, PCWrite);
        end
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd9;
        IFID_rs       = 5'd3;
        IFID_rt       = 5'd9;
        IFID_UsesRt   = 1'b1;
        #1;
        vectors++;
        if (PCWrite !== 1'b0 || IDEX_flush !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_rt got pcw=%b idf=%b want 0/1",
                     PCWrite, IDEX_flush);
        end
        IDEX_MemRead = 1'b0;
        #1;
        vectors++;
        if (PCWrite !== 1'b1 || IDEX_flush !== 1'b0) begin
            errors++;
            $display("FAIL no_memread got pcw=%b idf=%b want 1/0",
                     PCWrite, IDEX_flush);
        end
        clearInputs();
    endtask

    task automatic test_r0();
        doReset();
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd0;
        IFID_rs       = 5'd0;
        #1;
        vectors++;
        if (PCWrite !== 1'b1 || IDEX_flush !== 1'b0) begin
            errors++;
            $display("FAIL r0_nostall got pcw=%b idf=%b want 1/0",
                     PCWrite, IDEX_flush);
        end
        IDEX_RegAddrI = 5'd5;
        IFID_rs       = 5'd3;
        IFID_rt       = 5'd5;
        IFID_UsesRt   = 1'b0;
        #1;
        vectors++;
        if (PCWrite !== 1'b1 || IFIDWrite !== 1'b1) begin
            errors++;
            $display("FAIL rt_unused got pcw=%b ifw=%b want 1/1",
                     PCWrite, IFIDWrite);
        end
        tick();
        clearInputs();
        vectors++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL r0_stallcnt got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_branch_priority();
        doReset();
        branch_taken  = 1'b1;
        md_start      = 1'b1;
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd7;
        IFID_rs       = 5'd7;
        #1;
        vectors++;
        if ({PCWrite, IFIDWrite, IFID_flush, IDEX_flush} !== 4'b1111) begin
            errors++;
            $display("FAIL branch_outs got %b want 1111",
                     {PCWrite, IFIDWrite, IFID_flush, IDEX_flush});
        end
        tick();
        clearInputs();
        #1;
        vectors++;
        if (state !== 2'd0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL branch_after got st=%0d fc=%0d sc=%0d want 0/1/0",
                     state, flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_muldiv();
        int stalls = 0;
        int dones  = 0;
        bit seen   = 0;
        doReset();
        md_start = 1'b1;
        #1;
        vectors++;
        if (PCWrite !== 1'b1 || IDEX_flush !== 1'b0 || md_done !== 1'b0) begin
            errors++;
            $display("FAIL md_startcycle got pcw=%b idf=%b mdd=%b want 1/0/0",
                     PCWrite, IDEX_flush, md_done);
        end
        tick();
        md_start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            branch_taken = (state == 2'd1);
            md_start     = (state == 2'd1);
            #1;
            if (md_done === 1'b1) begin
                seen = 1;
                dones++;
                vectors++;
                if (state !== 2'd2 || PCWrite !== 1'b1 || IDEX_flush !== 1'b0) begin
                    errors++;
                    $display("FAIL md_donecycle got st=%0d pcw=%b idf=%b want 2/1/0",
                             state, PCWrite, IDEX_flush);
                end
            end else begin
                if (PCWrite === 1'b0) stalls++;
                vectors++;
                if (state !== 2'd1 || PCWrite !== 1'b0 || IDEX_flush !== 1'b1 ||
                    IFID_flush !== 1'b0) begin
                    errors++;
                    $display("FAIL md_busy cyc=%0d got st=%0d pcw=%b idf=%b iff=%b want 1/0/1/0",
                             i, state, PCWrite, IDEX_flush, IFID_flush);
                end
            end
            if (!seen) tick();
        end
        clearInputs();
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL md_done_timeout got no pulse want pulse");
        end
        vectors++;
        if (stalls != 7) begin
            errors++;
            $display("FAIL md_stallcycles got %0d want 7", stalls);
        end
        tick();
        vectors++;
        if (state !== 2'd0 || md_done !== 1'b0 || stall_cnt !== 16'd7 ||
            flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL md_after got st=%0d mdd=%b sc=%0d fc=%0d want 0/0/7/0",
                     state, md_done, stall_cnt, flush_cnt);
        end
        vectors++;
        if (dones != 1) begin
            errors++;
            $display("FAIL md_pulsecount got %0d want 1", dones);
        end
    endtask

    task automatic test_mddone_hazard();
        bit seen = 0;
        doReset();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (md_done === 1'b1) seen = 1;
            else tick();
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL mddone_timeout got no pulse want pulse");
        end
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd12;
        IFID_rs       = 5'd12;
        #1;
        vectors++;
        if ({PCWrite, IFIDWrite, IDEX_flush, md_done} !== 4'b0011) begin
            errors++;
            $display("FAIL mddone_hazard got %b want 0011",
                     {PCWrite, IFIDWrite, IDEX_flush, md_done});
        end
        tick();
        clearInputs();
        #1;
        vectors++;
        if (state !== 2'd0 || stall_cnt !== 16'd8) begin
            errors++;
            $display("FAIL mddone_after got st=%0d sc=%0d want 0/8",
                     state, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        doReset();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        vectors++;
        if (state !== 2'd1 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL midop_setup got st=%0d sc=%0d want 1/2",
                     state, stall_cnt);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midop_abort got st=%0d sc=%0d fc=%0d want 0/0/0",
                     state, stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done} !== 5'b00110) begin
                errors++;
                $display("FAIL midop_hold cyc=%0d got %b want 00110", i,
                         {PCWrite, IFIDWrite, IFID_flush, IDEX_flush, md_done});
            end
            tick();
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (md_done === 1'b1) pulses++;
            tick();
        end
        vectors++;
        if (pulses != 0 || state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midop_release got pulses=%0d st=%0d sc=%0d want 0/0/0",
                     pulses, state, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        doReset();
        IDEX_MemRead  = 1'b1;
        IDEX_RegAddrI = 5'd4;
        IFID_rs       = 5'd4;
        repeat (65534) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_before got %h want fffe", stall_cnt);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold got %h want ffff", stall_cnt);
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_branch_priority();
        test_muldiv();
        test_mddone_hazard();
        test_reset_mid_op();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
